// File: rtl/game_pkg.sv
// Shared definitions for the rectangle plotter: coordinate and colour widths,
// screen height, and the FSM state type used by the datapath and its controller.
package game_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

endpackage

// File: rtl/rect_plot_datapath_if.sv
// Load/plot bus between the game controller and the rectangle datapath, plus the
// VGA adapter pixel outputs.
// Handshake: ld_top/ld_bottom/ld_color are single-cycle strobes qualified by
// data_in on the same edge; plot_en is a level request that stays high until
// the controller sees done. busy is high while pixels are emitted, done pulses
// for one cycle after the last pixel, and plot qualifies x/y/colour each cycle.
interface rect_plot_datapath_if;
  import game_pkg::*;

  logic [9:0]     data_in;
  logic           ld_top;
  logic           ld_bottom;
  logic           ld_color;
  logic           plot_en;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [C_W-1:0] colour;
  logic           plot;
  logic           busy;
  logic           done;

  modport master (
    output data_in, ld_top, ld_bottom, ld_color, plot_en,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  data_in, ld_top, ld_bottom, ld_color, plot_en,
    output x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/rect_plot_datapath_xy_scan_counter.sv
// Nested x/y raster counter. start loads (X_LEFT, ylo) and captures yhi; the
// counter then steps one pixel per clock in row order and stops once it has
// shown (X_RIGHT, yhi), which is flagged by last.
module xy_scan_counter
  import game_pkg::*;
#(
  parameter int X_LEFT  = 0,
  parameter int X_RIGHT = 159
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [Y_W-1:0] ylo,
  input  logic [Y_W-1:0] yhi,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] XL = X_W'(X_LEFT);
  localparam logic [X_W-1:0] XR = X_W'(X_RIGHT);

  logic [Y_W-1:0] yhi_q;
  logic           run;

  assign last = run && (x == XR) && (y == yhi_q);

  // Position register: load on start, step while running, hold once finished.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x     <= XL;
      y     <= '0;
      yhi_q <= '0;
      run   <= 1'b0;
    end else if (start) begin
      x     <= XL;
      y     <= ylo;
      yhi_q <= yhi;
      run   <= 1'b1;
    end else if (run) begin
      if (last) begin
        run <= 1'b0;
      end else if (x == XR) begin
        x <= XL;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_plot_datapath.sv
// Rectangle plot datapath: latches row/colour from the switch bus, then scans
// X_LEFT..X_RIGHT by min(top,bottom)..max(top,bottom) one pixel per clock.
// Build option OUTLINE_EN: keep the scan timing but only strobe plot on the
// rectangle border.
module rect_plot_datapath #(
  parameter int X_LEFT   = 0,
  parameter int X_RIGHT  = 159,
  parameter int SCREEN_H = game_pkg::SCREEN_H
) (
  input  logic                   clk,
  input  logic                   reset,
  rect_plot_datapath_if.slave    bus,
  output game_pkg::state_t       state
);
  import game_pkg::*;

  localparam logic [Y_W-1:0] ROW_MAX = Y_W'(SCREEN_H - 1);

  state_t         state_q, state_d;
  logic [Y_W-1:0] top_q, bottom_q, row_in, row_c, ylo, yhi;
  logic [C_W-1:0] colour_q;
  logic [X_W-1:0] x_c;
  logic [Y_W-1:0] y_c;
  logic           start, last, load_ok, edge_px;

  assign row_in  = bus.data_in[Y_W-1:0];
  assign row_c   = (row_in > ROW_MAX) ? ROW_MAX : row_in;
  assign load_ok = (state_q == IDLE) || (state_q == WAIT_LOW);
  assign ylo     = (top_q < bottom_q) ? top_q : bottom_q;
  assign yhi     = (top_q < bottom_q) ? bottom_q : top_q;

  // Load registers; frozen from scan start through the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q    <= '0;
      bottom_q <= '0;
      colour_q <= '0;
    end else if (load_ok) begin
      if (bus.ld_top)    top_q    <= row_c;
      if (bus.ld_bottom) bottom_q <= row_c;
      if (bus.ld_color)  colour_q <= bus.data_in[9:10-C_W];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; start fires on the edge that enters SCAN.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.plot_en) begin
          state_d = SCAN;
          start   = 1'b1;
        end
      end
      SCAN:     if (last) state_d = DONE;
      DONE:     state_d = WAIT_LOW;
      WAIT_LOW: if (!bus.plot_en) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  xy_scan_counter #(
    .X_LEFT  (X_LEFT),
    .X_RIGHT (X_RIGHT)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ylo   (ylo),
    .yhi   (yhi),
    .x     (x_c),
    .y     (y_c),
    .last  (last)
  );

`ifdef OUTLINE_EN
  localparam logic [X_W-1:0] XL = X_W'(X_LEFT);
  localparam logic [X_W-1:0] XR = X_W'(X_RIGHT);
  assign edge_px = (x_c == XL) || (x_c == XR) || (y_c == ylo) || (y_c == yhi);
`else
  assign edge_px = 1'b1;
`endif

  // Outputs are decodes of registered state and the registered pixel position.
  assign bus.x      = x_c;
  assign bus.y      = y_c;
  assign bus.colour = colour_q;
  assign bus.busy   = (state_q == SCAN);
  assign bus.plot   = (state_q == SCAN) && edge_px;
  assign bus.done   = (state_q == DONE);
  assign state      = state_q;

endmodule

// File: tb/tb_rect_plot_datapath.sv
// Directed bench for rect_plot_datapath with X_LEFT=0, X_RIGHT=3, SCREEN_H=8.
module tb_rect_plot_datapath;
  import game_pkg::*;

  localparam int XR = 3;

  logic   clk;
  logic   reset;
  state_t dut_state;
  int     n_vec = 0;
  int     n_bad = 0;

  rect_plot_datapath_if bus();

  rect_plot_datapath #(
    .X_LEFT   (0),
    .X_RIGHT  (XR),
    .SCREEN_H (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (dut_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] top;
    logic [6:0] bottom;
    logic [2:0] col;
    logic [6:0] exp_ylo;
    logic [6:0] exp_yhi;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [31:0] pk(input logic p, input logic b, input logic d,
                                     input logic [7:0] xx, input logic [6:0] yy,
                                     input logic [2:0] c);
    return {11'b0, p, b, d, xx, yy, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_out();
    return pk(bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads top and colour together (two strobes, one cycle), then bottom.
  task automatic load(input logic [6:0] top, input logic [6:0] bottom, input logic [2:0] col);
    bus.data_in  = {col, top};
    bus.ld_top   = 1'b1;
    bus.ld_color = 1'b1;
    tick();
    bus.ld_top    = 1'b0;
    bus.ld_color  = 1'b0;
    bus.data_in   = {3'b000, bottom};
    bus.ld_bottom = 1'b1;
    tick();
    bus.ld_bottom = 1'b0;
    bus.data_in   = '0;
  endtask

  // One draw: plot_en held high, pixels checked in row order, done checked,
  // plot_en held a few more cycles, then dropped. ld_at pulses ld_top=5 on that
  // scan cycle; abort_at asserts reset on that scan cycle.
  task automatic draw(input logic [6:0] ylo, input logic [6:0] yhi, input logic [2:0] col,
                      input int ld_at, input int abort_at, input string tag);
    logic [7:0] ex;
    logic [6:0] ey;
    logic       ep;
    int         n;
    n  = (XR + 1) * (int'(yhi) - int'(ylo) + 1);
    ex = 8'd0;
    ey = ylo;
    bus.plot_en = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check({tag, " abort outputs"}, dut_out(), pk(1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0));
        check({tag, " abort state"}, 32'(dut_state), 32'(IDLE));
        bus.plot_en = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          tick();
          check({tag, " post abort quiet"}, dut_out(),
                pk(1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0));
        end
        return;
      end
`ifdef OUTLINE_EN
      ep = (ex == 8'd0) || (ex == 8'(XR)) || (ey == ylo) || (ey == yhi);
`else
      ep = 1'b1;
`endif
      check($sformatf("%s pixel %0d", tag, i), dut_out(), pk(ep, 1'b1, 1'b0, ex, ey, col));
      if (i == ld_at) begin
        bus.data_in = 10'd5;
        bus.ld_top  = 1'b1;
      end else begin
        bus.ld_top  = 1'b0;
      end
      tick();
      if (ex == 8'(XR)) begin
        ex = 8'd0;
        ey = ey + 7'd1;
      end else begin
        ex = ex + 8'd1;
      end
    end
    bus.ld_top = 1'b0;
    check({tag, " done pulse"}, {31'b0, bus.done}, 32'd1);
    check({tag, " done plot/busy"}, {30'b0, bus.plot, bus.busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check({tag, " held high quiet"}, {29'b0, bus.plot, bus.busy, bus.done}, 32'd0);
    end
    check({tag, " wait_low"}, 32'(dut_state), 32'(WAIT_LOW));
    bus.plot_en = 1'b0;
    tick();
    check({tag, " back to idle"}, 32'(dut_state), 32'(IDLE));
  endtask

  initial begin
    vecs[0] = '{top: 7'd2,   bottom: 7'd4,   col: 3'd5, exp_ylo: 7'd2, exp_yhi: 7'd4};
    vecs[1] = '{top: 7'd6,   bottom: 7'd1,   col: 3'd3, exp_ylo: 7'd1, exp_yhi: 7'd6};
    vecs[2] = '{top: 7'd3,   bottom: 7'd3,   col: 3'd1, exp_ylo: 7'd3, exp_yhi: 7'd3};
    vecs[3] = '{top: 7'd12,  bottom: 7'd100, col: 3'd6, exp_ylo: 7'd7, exp_yhi: 7'd7};
    vecs[4] = '{top: 7'd0,   bottom: 7'd3,   col: 3'd7, exp_ylo: 7'd0, exp_yhi: 7'd3};

    // Reset.
    reset         = 1'b1;
    bus.data_in   = '0;
    bus.ld_top    = 1'b0;
    bus.ld_bottom = 1'b0;
    bus.ld_color  = 1'b0;
    bus.plot_en   = 1'b0;
    tick();
    tick();
    check("reset outputs", dut_out(), pk(1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0));
    check("reset state", 32'(dut_state), 32'(IDLE));
    reset = 1'b0;
    tick();

    // Table of load/draw vectors.
    for (int v = 0; v < 5; v++) begin
      load(vecs[v].top, vecs[v].bottom, vecs[v].col);
      draw(vecs[v].exp_ylo, vecs[v].exp_yhi, vecs[v].col, -1, -1, $sformatf("vec%0d", v));
    end

    // Load strobe during scan is ignored, now and for the following draw.
    draw(7'd0, 7'd3, 3'd7, 3, -1, "ld_busy");
    draw(7'd0, 7'd3, 3'd7, -1, -1, "after_ld_busy");

    // Reset in the middle of a scan.
    draw(7'd0, 7'd3, 3'd7, -1, 5, "abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
